// File: rtl/dqt_marker_gen_if.sv
// dqt_marker_gen_if: byte stream carrying the DQT marker to the header writer.
//   m_tdata  : marker byte
//   m_tvalid : byte valid
//   m_tready : downstream accept
//   m_tlast  : final marker byte
interface dqt_marker_gen_if;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/dqt_marker_gen.sv
// dqt_marker_gen: on start, scales the IJG luma/chroma base tables by a JPEG
// quality factor, builds fixed-point reciprocal tables for the quantizer and
// streams the complete DQT marker byte-by-byte.
//   clk, rst          : clock, asynchronous active-high reset
//   start_i/quality_i : request (honoured only when idle) and quality factor
//   busy_o            : run in progress
//   tables_valid_o    : reciprocal tables hold the latest quality's values
//   y/uv_recip_table_o: reciprocals, [row][col] natural order
//   m_if              : marker byte stream (master)
module dqt_marker_gen #(
    parameter int QUAN_BITWIDTH = 16,
    parameter int NUM_TABLES    = 2,
    parameter int ZIGZAG        = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic [6:0] quality_i,
    output logic busy_o,
    output logic tables_valid_o,
    output logic [7:0][7:0][QUAN_BITWIDTH-1:0] y_recip_table_o,
    output logic [7:0][7:0][QUAN_BITWIDTH-1:0] uv_recip_table_o,
    dqt_marker_gen_if.master m_if
);
    localparam int LQ     = 2 + 65 * NUM_TABLES;
    localparam int NBYTES = 2 + LQ;
    localparam int NENT   = 64 * NUM_TABLES;
    // Dividend must hold base*scale+50 (< 2^20) and 2^QUAN_BITWIDTH.
    localparam int DW     = (QUAN_BITWIDTH + 1 > 20) ? QUAN_BITWIDTH + 1 : 20;
    localparam int CW     = $clog2(DW + 1);
    localparam logic [15:0] LQW = 16'(LQ);

    localparam logic [6:0] LUMA [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68,109,103, 77,   24, 35, 55, 64, 81,104,113, 92,
        49, 64, 78, 87,103,121,120,101,   72, 92, 95, 98,112,100,103, 99};
    localparam logic [6:0] CHROMA [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99};
    localparam logic [5:0] ZZ [64] = '{
         0, 1, 8,16, 9, 2, 3,10,  17,24,32,25,18,11, 4, 5,
        12,19,26,33,40,48,41,34,  27,20,13, 6, 7,14,21,28,
        35,42,49,56,57,50,43,36,  29,22,15,23,30,37,44,51,
        58,59,52,45,38,31,39,46,  53,60,61,54,47,55,62,63};

    typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;
    typedef enum logic [1:0] {PH_SCALE, PH_ENT, PH_RCP} phase_t;

    state_t state_q, state_d;
    phase_t phase_q;
    logic [6:0]  qual_q, q_clamp, base;
    logic [12:0] scale_q;
    logic [6:0]  idx_q;
    logic [7:0]  e_q, ent_clamp;
    logic [DW-1:0] dq_q, dq_nx;
    logic [7:0]  rem_q, rem_nx, dvs_q;
    logic [8:0]  trial;
    logic        ge, dbusy_q, div_last;
    logic [CW-1:0] cnt_q;
    logic [QUAN_BITWIDTH-1:0] rcp;
    logic        tv_q, tlast_q, accept, calc_done, hs, last_hs;
    logic [7:0]  tdata_q, bidx_q;
    logic [7:0][7:0][QUAN_BITWIDTH-1:0] y_q, uv_q;
    logic [7:0]  ent_q [128];       // scaled entry bytes, luma at 0..63, chroma at 64..127
    logic [7:0]  nxt_k, off, r, nxt_byte;
    logic [5:0]  rm1, pos;
    logic        tsel, nxt_last;

    assign q_clamp  = (quality_i == 7'd0) ? 7'd1 : ((quality_i > 7'd100) ? 7'd100 : quality_i);
    assign accept   = start_i && (state_q == IDLE);
    assign base     = idx_q[6] ? CHROMA[idx_q[5:0]] : LUMA[idx_q[5:0]];

    // One restoring-division step: shift next dividend bit into the remainder.
    assign trial    = {rem_q, dq_q[DW-1]};
    assign ge       = (trial >= {1'b0, dvs_q});
    assign rem_nx   = ge ? 8'(trial - {1'b0, dvs_q}) : trial[7:0];
    assign dq_nx    = {dq_q[DW-2:0], ge};
    assign div_last = dbusy_q && (cnt_q == CW'(1));

    assign ent_clamp = (dq_nx == '0) ? 8'd1 : ((dq_nx > DW'(255)) ? 8'd255 : dq_nx[7:0]);
    assign rcp       = (|dq_nx[DW-1:QUAN_BITWIDTH]) ? '1 : dq_nx[QUAN_BITWIDTH-1:0];

    assign calc_done = (state_q == CALC) && div_last && (phase_q == PH_RCP) && (idx_q == 7'(NENT - 1));
    assign hs        = (state_q == EMIT) && m_if.m_tready;
    assign last_hs   = hs && (bidx_q == 8'(NBYTES - 1));

    // Byte following the one currently presented.
    always_comb begin
        nxt_k    = bidx_q + 8'd1;
        off      = nxt_k - 8'd4;
        tsel     = (off >= 8'd65);
        r        = tsel ? off - 8'd65 : off;
        rm1      = r[5:0] - 6'd1;
        pos      = (ZIGZAG != 0) ? ZZ[rm1] : rm1;
        nxt_last = (nxt_k == 8'(NBYTES - 1));
        if (nxt_k == 8'd1)      nxt_byte = 8'hDB;
        else if (nxt_k == 8'd2) nxt_byte = LQW[15:8];
        else if (nxt_k == 8'd3) nxt_byte = LQW[7:0];
        else if (r == 8'd0)     nxt_byte = {7'd0, tsel};
        else                    nxt_byte = ent_q[{tsel, pos}];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = CALC;
            CALC:    if (calc_done) state_d = EMIT;
            EMIT:    if (last_hs)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_SCALE;
            qual_q  <= '0;
            scale_q <= '0;
            idx_q   <= '0;
            e_q     <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbusy_q <= 1'b0;
            tv_q    <= 1'b0;
            y_q     <= '0;
            uv_q    <= '0;
            bidx_q  <= '0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
        end else if (accept) begin
            qual_q  <= q_clamp;
            tv_q    <= 1'b0;
            idx_q   <= '0;
            dbusy_q <= 1'b0;
            // High qualities need no division for the scale factor.
            if (q_clamp < 7'd50) begin
                phase_q <= PH_SCALE;
            end else begin
                phase_q <= PH_ENT;
                scale_q <= 13'd200 - {5'd0, q_clamp, 1'b0};
            end
        end else if (state_q == CALC) begin
            if (!dbusy_q) begin
                rem_q   <= '0;
                cnt_q   <= CW'(DW);
                dbusy_q <= 1'b1;
                case (phase_q)
                    PH_SCALE: begin dq_q <= DW'(5000); dvs_q <= {1'b0, qual_q}; end
                    PH_ENT:   begin dq_q <= DW'(base) * DW'(scale_q) + DW'(50); dvs_q <= 8'd100; end
                    default:  begin dq_q <= DW'(1) << QUAN_BITWIDTH; dvs_q <= e_q; end
                endcase
            end else begin
                dq_q    <= dq_nx;
                rem_q   <= rem_nx;
                cnt_q   <= cnt_q - CW'(1);
                dbusy_q <= !div_last;
                if (div_last) begin
                    case (phase_q)
                        PH_SCALE: begin scale_q <= dq_nx[12:0]; phase_q <= PH_ENT; end
                        PH_ENT:   begin e_q <= ent_clamp; phase_q <= PH_RCP; end
                        default: begin
                            if (idx_q[6]) uv_q[idx_q[5:3]][idx_q[2:0]] <= rcp;
                            else          y_q[idx_q[5:3]][idx_q[2:0]]  <= rcp;
                            idx_q   <= idx_q + 7'd1;
                            phase_q <= PH_ENT;
                        end
                    endcase
                end
                if (calc_done) begin
                    tv_q    <= 1'b1;
                    bidx_q  <= '0;
                    tdata_q <= 8'hFF;
                    tlast_q <= 1'b0;
                end
            end
        end else if (hs) begin
            if (last_hs) begin
                tdata_q <= '0;
                tlast_q <= 1'b0;
            end else begin
                bidx_q  <= nxt_k;
                tdata_q <= nxt_byte;
                tlast_q <= nxt_last;
            end
        end
    end

    // Entry buffer needs no reset: every slot is written before EMIT reads it.
    always_ff @(posedge clk) begin
        if (state_q == CALC && div_last && phase_q == PH_ENT)
            ent_q[idx_q] <= ent_clamp;
    end

    assign busy_o           = (state_q != IDLE);
    assign tables_valid_o   = tv_q;
    assign y_recip_table_o  = y_q;
    assign uv_recip_table_o = uv_q;
    assign m_if.m_tdata     = tdata_q;
    assign m_if.m_tvalid    = (state_q == EMIT);
    assign m_if.m_tlast     = tlast_q;
endmodule

// File: tb/tb_dqt_marker_gen.sv
module tb_dqt_marker_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [6:0] quality = '0;
    logic rdy = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] busy, tv, tvalid, tlast;
    logic [7:0] tdata [3];
    logic [7:0][7:0][15:0] y0, uv0, y1, uv1, y2, uv2;

    dqt_marker_gen_if if0 ();
    dqt_marker_gen_if if1 ();
    dqt_marker_gen_if if2 ();
    assign if0.m_tready = rdy;
    assign if1.m_tready = rdy;
    assign if2.m_tready = rdy;
    assign tdata[0] = if0.m_tdata; assign tvalid[0] = if0.m_tvalid; assign tlast[0] = if0.m_tlast;
    assign tdata[1] = if1.m_tdata; assign tvalid[1] = if1.m_tvalid; assign tlast[1] = if1.m_tlast;
    assign tdata[2] = if2.m_tdata; assign tvalid[2] = if2.m_tvalid; assign tlast[2] = if2.m_tlast;

    dqt_marker_gen #(.QUAN_BITWIDTH(16), .NUM_TABLES(2), .ZIGZAG(1)) u0 (
        .clk(clk), .rst(rst), .start_i(start), .quality_i(quality), .busy_o(busy[0]),
        .tables_valid_o(tv[0]), .y_recip_table_o(y0), .uv_recip_table_o(uv0), .m_if(if0));
    dqt_marker_gen #(.QUAN_BITWIDTH(16), .NUM_TABLES(2), .ZIGZAG(0)) u1 (
        .clk(clk), .rst(rst), .start_i(start), .quality_i(quality), .busy_o(busy[1]),
        .tables_valid_o(tv[1]), .y_recip_table_o(y1), .uv_recip_table_o(uv1), .m_if(if1));
    dqt_marker_gen #(.QUAN_BITWIDTH(16), .NUM_TABLES(1), .ZIGZAG(1)) u2 (
        .clk(clk), .rst(rst), .start_i(start), .quality_i(quality), .busy_o(busy[2]),
        .tables_valid_o(tv[2]), .y_recip_table_o(y2), .uv_recip_table_o(uv2), .m_if(if2));

    int LUM [64] = '{16,11,10,16,24,40,51,61, 12,12,14,19,26,58,60,55, 14,13,16,24,40,57,69,56,
                     14,17,22,29,51,87,80,62, 18,22,37,56,68,109,103,77, 24,35,55,64,81,104,113,92,
                     49,64,78,87,103,121,120,101, 72,92,95,98,112,100,103,99};
    int CHR [64] = '{17,18,24,47,99,99,99,99, 18,21,26,66,99,99,99,99, 24,26,56,99,99,99,99,99,
                     47,66,99,99,99,99,99,99, 99,99,99,99,99,99,99,99, 99,99,99,99,99,99,99,99,
                     99,99,99,99,99,99,99,99, 99,99,99,99,99,99,99,99};
    int ZZT [64] = '{0,1,8,16,9,2,3,10, 17,24,32,25,18,11,4,5, 12,19,26,33,40,48,41,34,
                     27,20,13,6,7,14,21,28, 35,42,49,56,57,50,43,36, 29,22,15,23,30,37,44,51,
                     58,59,52,45,38,31,39,46, 53,60,61,54,47,55,62,63};
    int NT [3] = '{2, 2, 1};
    int ZM [3] = '{1, 0, 1};

    // kind: 0 = stream byte, 1 = luma reciprocal, 2 = chroma reciprocal (natural index)
    typedef struct { int q; int inst; int kind; int idx; int expv; string name; } vec_t;
    vec_t vecs [$];

    int checks = 0;
    int errors = 0;
    logic [7:0] got [3][$];
    int lastpos [3];
    int nlast [3];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int m_entry(input int q, input int t, input int n);
        int qc, sc, e;
        qc = (q == 0) ? 1 : ((q > 100) ? 100 : q);
        sc = (qc < 50) ? 5000 / qc : 200 - 2 * qc;
        e  = ((t ? CHR[n] : LUM[n]) * sc + 50) / 100;
        if (e < 1) e = 1;
        if (e > 255) e = 255;
        return e;
    endfunction

    function automatic int m_recip(input int e);
        int r;
        r = 65536 / e;
        return (r > 65535) ? 65535 : r;
    endfunction

    function automatic int m_byte(input int q, input int nt, input int zz, input int k);
        int o, t, r;
        case (k)
            0: return 255;
            1: return 219;
            2: return 0;
            3: return (nt == 2) ? 132 : 67;
            default: ;
        endcase
        o = k - 4; t = o / 65; r = o % 65;
        if (r == 0) return t;
        return m_entry(q, t, zz ? ZZT[r - 1] : r - 1);
    endfunction

    function automatic int get_recip(input int i, input int t, input int n);
        case (i)
            0: return t ? int'(uv0[n / 8][n % 8]) : int'(y0[n / 8][n % 8]);
            1: return t ? int'(uv1[n / 8][n % 8]) : int'(y1[n / 8][n % 8]);
            default: return t ? int'(uv2[n / 8][n % 8]) : int'(y2[n / 8][n % 8]);
        endcase
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_tables_valid"}, int'(tv), 0);
        chk({tag, "_tvalid"}, int'(tvalid), 0);
        chk({tag, "_tlast"}, int'(tlast), 0);
        chk({tag, "_tdata"}, int'({tdata[0], tdata[1], tdata[2]}), 0);
        chk({tag, "_tables_nonzero"}, int'({y0, uv0, y1, uv1, y2, uv2} != '0), 0);
    endtask

    // Start one run, collect all three streams; abort_at > 0 returns early
    // once instance 0 has transferred that many bytes.
    task automatic run(input int q, input bit stall, input bit pulse, input int abort_at);
        int cyc;
        bit done [3], fin [3], held [3];
        logic [7:0] hd [3];
        logic hl [3];
        bit pulsed_e;
        for (int i = 0; i < 3; i++) begin
            got[i].delete(); lastpos[i] = -1; nlast[i] = 0;
            done[i] = 0; fin[i] = 0; held[i] = 0;
        end
        pulsed_e = 0;
        @(negedge clk); start = 1'b1; quality = 7'(q);
        @(negedge clk); start = 1'b0;
        chk($sformatf("q%0d_busy_after_start", q), int'(busy), 7);
        chk($sformatf("q%0d_tables_valid_cleared", q), int'(tv), 0);
        cyc = 0;
        while (!(done[0] && done[1] && done[2]) && cyc < 20000) begin
            start = 1'b0;
            if (pulse && cyc == 100) begin start = 1'b1; quality = 7'd3; end
            if (pulse && !pulsed_e && (&tvalid)) begin start = 1'b1; quality = 7'd5; pulsed_e = 1; end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (fin[i] && !done[i]) begin
                    chk($sformatf("q%0d_inst%0d_idle_after_last", q, i), int'({busy[i], tvalid[i]}), 0);
                    done[i] = 1;
                end else if (!done[i] && tvalid[i]) begin
                    if (held[i]) begin
                        chk($sformatf("q%0d_inst%0d_stall_tdata", q, i), int'(tdata[i]), int'(hd[i]));
                        chk($sformatf("q%0d_inst%0d_stall_tlast", q, i), int'(tlast[i]), int'(hl[i]));
                    end else if (got[i].size() == 0) begin
                        chk($sformatf("q%0d_inst%0d_tv_at_emit", q, i), int'(tv[i]), 1);
                    end
                    if (rdy) begin
                        got[i].push_back(tdata[i]);
                        if (tlast[i]) begin nlast[i]++; lastpos[i] = got[i].size() - 1; end
                        held[i] = 0;
                        if (got[i].size() == 4 + 65 * NT[i]) fin[i] = 1;
                    end else begin
                        held[i] = 1; hd[i] = tdata[i]; hl[i] = tlast[i];
                    end
                end
            end
            if (abort_at > 0 && got[0].size() >= abort_at) return;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(done[0] && done[1] && done[2])) begin
            errors++;
            $display("FAIL q%0d_timeout: got bytes %0d/%0d/%0d required completion within budget",
                     q, got[0].size(), got[1].size(), got[2].size());
        end
    endtask

    task automatic verify(input int q);
        int bad, bv, ev;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("q%0d_inst%0d_len", q, i), got[i].size(), 4 + 65 * NT[i]);
            chk($sformatf("q%0d_inst%0d_tlast_count", q, i), nlast[i], 1);
            chk($sformatf("q%0d_inst%0d_tlast_pos", q, i), lastpos[i], 3 + 65 * NT[i]);
            bad = -1; bv = 0; ev = 0;
            for (int k = 0; k < got[i].size() && bad < 0; k++)
                if (int'(got[i][k]) != m_byte(q, NT[i], ZM[i], k)) begin
                    bad = k; bv = int'(got[i][k]); ev = m_byte(q, NT[i], ZM[i], k);
                end
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL q%0d_inst%0d_stream byte %0d: got %02h expected %02h", q, i, bad, bv, ev);
            end
            for (int t = 0; t < 2; t++) begin
                bad = -1;
                for (int n = 0; n < 64 && bad < 0; n++) begin
                    ev = (t < NT[i]) ? m_recip(m_entry(q, t, n)) : 0;
                    if (get_recip(i, t, n) != ev) begin bad = n; bv = get_recip(i, t, n); end
                end
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL q%0d_inst%0d_recip_t%0d entry %0d: got %0d expected %0d", q, i, t, bad, bv,
                             (t < NT[i]) ? m_recip(m_entry(q, t, bad)) : 0);
                end
            end
            chk($sformatf("q%0d_inst%0d_tables_valid", q, i), int'(tv[i]), 1);
        end
        foreach (vecs[v]) if (vecs[v].q == q) begin
            if (vecs[v].kind == 0)
                chk(vecs[v].name, (vecs[v].idx < got[vecs[v].inst].size()) ? int'(got[vecs[v].inst][vecs[v].idx]) : -1,
                    vecs[v].expv);
            else
                chk(vecs[v].name, get_recip(vecs[v].inst, vecs[v].kind - 1, vecs[v].idx), vecs[v].expv);
        end
    endtask

    initial begin
        vecs.push_back(vec_t'{50, 0, 0, 0, 'hFF, "q50_b0_ff"});
        vecs.push_back(vec_t'{50, 0, 0, 1, 'hDB, "q50_b1_db"});
        vecs.push_back(vec_t'{50, 0, 0, 2, 'h00, "q50_lq_hi"});
        vecs.push_back(vec_t'{50, 0, 0, 3, 'h84, "q50_lq_lo"});
        vecs.push_back(vec_t'{50, 0, 0, 4, 'h00, "q50_pqtq0"});
        vecs.push_back(vec_t'{50, 0, 0, 5, 'h10, "q50_y_zz0"});
        vecs.push_back(vec_t'{50, 0, 0, 6, 'h0B, "q50_y_zz1"});
        vecs.push_back(vec_t'{50, 0, 0, 7, 'h0C, "q50_y_zz2"});
        vecs.push_back(vec_t'{50, 0, 0, 8, 'h0E, "q50_y_zz3"});
        vecs.push_back(vec_t'{50, 0, 0, 9, 'h0C, "q50_y_zz4"});
        vecs.push_back(vec_t'{50, 0, 0, 10, 'h0A, "q50_y_zz5"});
        vecs.push_back(vec_t'{50, 0, 0, 69, 'h01, "q50_pqtq1"});
        vecs.push_back(vec_t'{50, 0, 0, 70, 'h11, "q50_uv_zz0"});
        vecs.push_back(vec_t'{50, 0, 0, 71, 'h12, "q50_uv_zz1"});
        vecs.push_back(vec_t'{50, 0, 0, 72, 'h12, "q50_uv_zz2"});
        vecs.push_back(vec_t'{50, 0, 0, 73, 'h18, "q50_uv_zz3"});
        vecs.push_back(vec_t'{50, 0, 1, 0, 4096, "q50_yrecip0"});
        vecs.push_back(vec_t'{50, 2, 0, 3, 'h43, "q50_nt1_lq_lo"});
        vecs.push_back(vec_t'{50, 2, 0, 68, 'h63, "q50_nt1_lastbyte"});
        vecs.push_back(vec_t'{25, 1, 0, 5, 'h20, "q25_nat_b0"});
        vecs.push_back(vec_t'{25, 1, 1, 0, 2048, "q25_yrecip0"});
        vecs.push_back(vec_t'{90, 0, 0, 5, 'h03, "q90_b0"});
        vecs.push_back(vec_t'{90, 0, 1, 0, 21845, "q90_yrecip0"});
        vecs.push_back(vec_t'{100, 0, 0, 5, 'h01, "q100_b0"});
        vecs.push_back(vec_t'{100, 0, 1, 0, 65535, "q100_yrecip0"});
        vecs.push_back(vec_t'{100, 0, 2, 63, 65535, "q100_uvrecip63"});
        vecs.push_back(vec_t'{10, 0, 0, 133, 'hFF, "q10_uv_last"});
        vecs.push_back(vec_t'{10, 0, 2, 63, 257, "q10_uvrecip63"});
        vecs.push_back(vec_t'{10, 2, 0, 68, 'hFF, "q10_nt1_lastbyte"});
        vecs.push_back(vec_t'{0, 0, 0, 5, 'hFF, "q0_b0"});
        vecs.push_back(vec_t'{0, 0, 1, 0, 257, "q0_yrecip0"});
        vecs.push_back(vec_t'{120, 0, 0, 5, 'h01, "q120_b0"});
        vecs.push_back(vec_t'{75, 0, 0, 5, 'h08, "q75_b0"});

        repeat (3) @(negedge clk);
        chk_reset("init");
        rst = 1'b0;

        run(50, 0, 0, 0);  verify(50);
        run(25, 0, 0, 0);  verify(25);
        run(90, 0, 0, 0);  verify(90);
        run(100, 0, 0, 0); verify(100);
        run(10, 0, 0, 0);  verify(10);
        run(0, 0, 0, 0);   verify(0);
        run(120, 0, 0, 0); verify(120);
        run(50, 1, 0, 0);  verify(50);
        run(50, 0, 1, 0);  verify(50);

        run(50, 0, 0, 20);
        rst = 1'b1;
        #1;
        chk_reset("mid_emit_rst");
        @(negedge clk);
        rst = 1'b0;
        run(75, 0, 0, 0);  verify(75);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dqt_marker_gen.md
Name: dqt_marker_gen

Overview:
- Sequential successor to the static DQT table block.
- Latches a JPEG quality factor at `start` and scales the standard luma/chroma base tables with the IJG formula.
- Computes fixed-point reciprocal tables for the quantizer.
- Streams the complete DQT marker byte-by-byte over a valid/ready interface into the header writer, in zigzag or natural order.

Parameters:
- `QUAN_BITWIDTH`, 16, reciprocal width; reciprocal = floor(2^QUAN_BITWIDTH / q), saturated.
- `NUM_TABLES`, 2, 1 = luma only (Tq=0); 2 = luma (Tq=0) + chroma (Tq=1).
- `ZIGZAG`, 1, 1 = emit the 64 table bytes in JPEG zigzag order; 0 = natural raster order.
- `LQ`, 2+65*NUM_TABLES, marker length field (0x0043 or 0x0084); derived, not overridable.

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle request; accepted only in IDLE
- `quality`  in  7  quality factor; sampled on accepted start
- `busy`  out  1  high from the cycle after accepted start until the last marker byte is accepted
- `tables_valid`  out  1  reciprocal tables valid
- `y_recip_table`  out  [8][8][QUAN_BITWIDTH]  packed; [row][col] natural order
- `uv_recip_table`  out  [8][8][QUAN_BITWIDTH]  packed; all zero when NUM_TABLES=1
- `m_tdata`  out  8  marker byte
- `m_tvalid`  out  1  byte valid
- `m_tready`  in  1  downstream accept
- `m_tlast`  out  1  high with the final marker byte

Behaviour:
- Reset: `busy`=0, `tables_valid`=0, both tables all-zero, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, state IDLE. Reset mid-CALC or mid-EMIT aborts immediately; no partial marker resumes.
- Base tables: standard IJG luma (16,11,10,16,...,99) and chroma (17,18,24,47,99,...) in natural order.
- Quality clamp: q = 0 → 1; q > 100 → 100.
- Scale: q < 50 → floor(5000/q); otherwise 200 − 2q.
- Entry: e = floor((base*scale + 50)/100), clamped to [1,255]. Intermediate width is at least 20 bits.
- Reciprocal: floor(2^QUAN_BITWIDTH / e), saturated to 2^QUAN_BITWIDTH − 1 when e = 1.
- FSM states: IDLE → CALC → EMIT → IDLE.
- IDLE:
  - `start`=1 latches the clamped quality, clears `tables_valid`, and enters CALC next cycle.
  - `start` outside IDLE is ignored, with no effect on latched state.
- CALC:
  - A single shared sequential restoring divider produces one quotient bit per cycle.
  - It computes scale (once), then for each entry the scaled value and then its reciprocal.
  - Entries are processed in natural order, luma first, then chroma.
  - Scaled entry bytes are stored in an internal 64×NUM_TABLES×8 byte buffer.
  - Each reciprocal is written into its output table slot as it completes.
  - When the last entry finishes, `tables_valid` goes to 1 in the same cycle EMIT begins.
- EMIT:
  - Byte sequence: FF, DB, LQ[15:8], LQ[7:0], then per table: Pq/Tq byte (0x00 or 0x01) followed by 64 entry bytes.
  - Entry byte k is buffer[zz(k)] when ZIGZAG=1 (zz = standard zigzag map 0,1,8,16,9,2,3,10,...), else buffer[k].
  - Total bytes = 2+LQ (69 or 134).
  - `m_tvalid` is high throughout EMIT.
  - `m_tdata` and `m_tlast` are registered and held stable while `m_tvalid` && !`m_tready`.
  - The byte index advances only on `m_tvalid` && `m_tready`.
  - `m_tlast` is high only on the final byte.
  - The handshake of the last byte returns the FSM to IDLE: `busy`=0 and `m_tvalid`=0 next cycle.
  - Tables remain valid until the next accepted start.
- No bubbles: with `m_tready` held high, one byte transfers per cycle, beginning the first EMIT cycle.

Test Plan:
- Quality 50, NUM_TABLES=2, ZIGZAG=1, `m_tready`=1 → stream begins FF DB 00 84 00 10 0B 0C 0E 0C 0A; the 70th byte is 01, then 11 12 12 18; 134 bytes total; `m_tlast` on byte 134; `y_recip_table`[0][0] = 4096.
- Quality 25, ZIGZAG=0 → luma byte 0 = 0x20; `y_recip_table`[0][0] = 2048. Quality 90 → e = 3, recip 21845.
- Quality 100 → all entry bytes 01; all reciprocals 0xFFFF. Quality 10 → chroma 99 entries clamp to 0xFF, recip 257. Quality 0 behaves as quality 1.
- Random `m_tready` backpressure (≈50% duty) → `m_tdata`/`m_tlast` never change while stalled; byte sequence identical to the no-stall run.
- `start` pulsed during CALC and during EMIT → ignored; output identical. NUM_TABLES=1 → LQ = 0x0043, 69 bytes, `uv_recip_table` = 0.
- Assert `rst` mid-EMIT, then restart at quality 75 → all outputs return to reset values; the new stream is complete from FF DB; `tables_valid` reflects the new tables only.
